// File: rtl/decode_stage.sv
// Decode/operand-fetch stage feeding the ALU.
// Decodes RV32I OP and OP-IMM words, reads the 32x32 register file (with
// writeback bypass), and presents operands through one registered output
// slot guarded by a valid/ready handshake. Unsupported opcodes are dropped
// and flagged with a one-cycle illegal pulse.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic [4:0]      rd_addr,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // Register file; entry 0 is never written so it stays zero.
  logic [XLEN-1:0] regs_q [NREGS];

  // Output slot and the source indices needed for held-operand updates.
  logic            out_valid_q, out_valid_d;
  logic            illegal_q,   illegal_d;
  logic [2:0]      funct3_q,    funct3_d;
  logic [6:0]      funct7_q,    funct7_d;
  logic [XLEN-1:0] rs1_q,       rs1_d;
  logic [XLEN-1:0] rs2_q,       rs2_d;
  logic [4:0]      rd_addr_q,   rd_addr_d;
  logic [4:0]      rs1_idx_q,   rs1_idx_d;
  logic [4:0]      rs2_idx_q,   rs2_idx_d;
  logic            is_op_q,     is_op_d;

  // Decode fields of the incoming word.
  logic [6:0]      opcode;
  logic [4:0]      src1_idx;
  logic [4:0]      src2_idx;
  logic            dec_op;
  logic            dec_op_imm;
  logic            accept;
  logic            wb_live;
  logic [XLEN-1:0] src1_val;
  logic [XLEN-1:0] src2_val;
  logic [XLEN-1:0] imm_sext;

  assign opcode      = instr[6:0];
  assign src1_idx    = instr[19:15];
  assign src2_idx    = instr[24:20];
  assign dec_op      = (opcode == OPC_OP);
  assign dec_op_imm  = (opcode == OPC_OP_IMM);
  assign instr_ready = !out_valid_q || out_ready;
  assign accept      = instr_valid && instr_ready;
  assign wb_live     = wb_en && (wb_addr != 5'd0);
  assign imm_sext    = {{20{instr[31]}}, instr[31:20]};

  // Operand read with same-cycle writeback bypass; x0 always reads zero.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    src1_val = '0;
    src2_val = '0;
    if (src1_idx != 5'd0) begin
      src1_val = (wb_live && wb_addr == src1_idx) ? wb_data : regs_q[src1_idx];
    end
    if (src2_idx != 5'd0) begin
      src2_val = (wb_live && wb_addr == src2_idx) ? wb_data : regs_q[src2_idx];
    end
  end

  // Next state of the output slot: load, drop, drain, or hold with operand refresh.
  always_comb begin
    out_valid_d = out_valid_q;
    illegal_d   = 1'b0;
    funct3_d    = funct3_q;
    funct7_d    = funct7_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_addr_d   = rd_addr_q;
    rs1_idx_d   = rs1_idx_q;
    rs2_idx_d   = rs2_idx_q;
    is_op_d     = is_op_q;

    if (accept && (dec_op || dec_op_imm)) begin
      out_valid_d = 1'b1;
      funct3_d    = instr[14:12];
      funct7_d    = dec_op ? instr[31:25] : 7'b0;
      rs1_d       = src1_val;
      rs2_d       = dec_op ? src2_val : imm_sext;
      rd_addr_d   = instr[11:7];
      rs1_idx_d   = src1_idx;
      rs2_idx_d   = src2_idx;
      is_op_d     = dec_op;
    end else if (accept) begin
      illegal_d   = 1'b1;
      out_valid_d = out_valid_q && !out_ready;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q) begin
      if (wb_live && wb_addr == rs1_idx_q) rs1_d = wb_data;
      if (wb_live && is_op_q && wb_addr == rs2_idx_q) rs2_d = wb_data;
    end
  end

  // Output slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      funct3_q    <= '0;
      funct7_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_addr_q   <= '0;
      rs1_idx_q   <= '0;
      rs2_idx_q   <= '0;
      is_op_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      illegal_q   <= illegal_d;
      funct3_q    <= funct3_d;
      funct7_q    <= funct7_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_addr_q   <= rd_addr_d;
      rs1_idx_q   <= rs1_idx_d;
      rs2_idx_q   <= rs2_idx_d;
      is_op_q     <= is_op_d;
    end
  end

  // Register-file write port, independent of the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array is reset explicitly because x1..x31 must read zero after reset.
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_live) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  assign out_valid = out_valid_q;
  assign illegal   = illegal_q;
  assign funct3    = funct3_q;
  assign funct7    = funct7_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a table of back-to-back accepts plus
// hand-written stall, illegal-opcode and reset-mid-stall sequences.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd_addr;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .funct3      (funct3),
    .funct7      (funct7),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd_addr     (rd_addr),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    wb_en   = 1'b1;
    wb_addr = addr;
    wb_data = data;
    cycle();
    wb_en   = 1'b0;
  endtask

  initial begin
    //               instr          wb  addr   data   f3    f7         rs1           rs2           rd
    vecs[0] = '{32'h002081B3, 1'b0, 5'd0, 32'h0, 3'd0, 7'h00, 32'd5,        32'd3,        5'd3}; // add x3,x1,x2
    vecs[1] = '{32'h402081B3, 1'b0, 5'd0, 32'h0, 3'd0, 7'h20, 32'd5,        32'd3,        5'd3}; // sub
    vecs[2] = '{32'hFFF08213, 1'b0, 5'd0, 32'h0, 3'd0, 7'h00, 32'd5,        32'hFFFFFFFF, 5'd4}; // addi x4,x1,-1
    vecs[3] = '{32'h002081B3, 1'b1, 5'd1, 32'd7, 3'd0, 7'h00, 32'd7,        32'd3,        5'd3}; // bypass x1=7
    vecs[4] = '{32'h000001B3, 1'b1, 5'd0, 32'd1, 3'd0, 7'h00, 32'd0,        32'd0,        5'd3}; // add x3,x0,x0 + wb x0
    vecs[5] = '{32'h7FF0C293, 1'b0, 5'd0, 32'h0, 3'd4, 7'h00, 32'd7,        32'h000007FF, 5'd5}; // xori x5,x1,0x7ff
    vecs[6] = '{32'h40315313, 1'b0, 5'd0, 32'h0, 3'd5, 7'h00, 32'd3,        32'h00000403, 5'd6}; // srai x6,x2,3
    vecs[7] = '{32'h001133B3, 1'b0, 5'd0, 32'h0, 3'd3, 7'h00, 32'd3,        32'd7,        5'd7}; // sltu x7,x2,x1

    rst_n = 1'b0; instr_valid = 1'b0; instr = '0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset instr_ready", 32'(instr_ready), 32'd1);
    check("reset illegal", 32'(illegal), 32'd0);
    check("reset rs1", rs1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // add x6,x5,x5 reads reset-cleared x5
    instr_valid = 1'b1; instr = 32'h00528333;
    cycle();
    instr_valid = 1'b0;
    check("x5 rs1 after reset", rs1, 32'd0);
    check("x5 rs2 after reset", rs2, 32'd0);
    check("x5 rd_addr", 32'(rd_addr), 32'd6);
    cycle();
    check("drain out_valid", 32'(out_valid), 32'd0);

    wb_write(5'd1, 32'd5);
    wb_write(5'd2, 32'd3);

    // Back-to-back accepts with out_ready=1: each vector replaces the previous.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr_valid = 1'b1;
      instr   = vecs[i].instr;
      wb_en   = vecs[i].wb_en;
      wb_addr = vecs[i].wb_addr;
      wb_data = vecs[i].wb_data;
      cycle();
      wb_en = 1'b0;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d illegal", i), 32'(illegal), 32'd0);
      check($sformatf("vec%0d funct3", i), 32'(funct3), 32'(vecs[i].f3));
      check($sformatf("vec%0d funct7", i), 32'(funct7), 32'(vecs[i].f7));
      check($sformatf("vec%0d rs1", i), rs1, vecs[i].rs1);
      check($sformatf("vec%0d rs2", i), rs2, vecs[i].rs2);
      check($sformatf("vec%0d rd_addr", i), 32'(rd_addr), 32'(vecs[i].rd));
    end

    // Illegal opcode accepted while the last word is consumed.
    instr_valid = 1'b1; instr = 32'h00000073;
    cycle();
    instr_valid = 1'b0;
    check("illegal pulse", 32'(illegal), 32'd1);
    check("illegal out_valid", 32'(out_valid), 32'd0);
    check("illegal instr_ready", 32'(instr_ready), 32'd1);
    cycle();
    check("illegal one cycle", 32'(illegal), 32'd0);
    check("illegal out_valid stays 0", 32'(out_valid), 32'd0);

    // Stall on add x3,x1,x2 (x1=7, x2=3) with held-operand updates.
    out_ready = 1'b0;
    instr_valid = 1'b1; instr = 32'h002081B3;
    cycle();
    instr = 32'h402081B3; // must not be accepted during the stall
    check("stall out_valid", 32'(out_valid), 32'd1);
    check("stall instr_ready", 32'(instr_ready), 32'd0);
    check("stall rs1", rs1, 32'd7);
    cycle();
    check("stall held funct7", 32'(funct7), 32'd0);
    check("stall held rs2", rs2, 32'd3);
    instr_valid = 1'b0;
    wb_write(5'd1, 32'd9);
    check("stall rs1 refresh", rs1, 32'd9);
    check("stall rs2 unchanged", rs2, 32'd3);
    wb_write(5'd2, 32'd11);
    check("stall rs2 refresh", rs2, 32'd11);
    check("stall out_valid held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cycle();
    check("release out_valid", 32'(out_valid), 32'd0);

    // OP-IMM stall: rs2 is the immediate and must ignore a wb to x31.
    out_ready = 1'b0;
    instr_valid = 1'b1; instr = 32'hFFF08213;
    cycle();
    instr_valid = 1'b0;
    wb_write(5'd31, 32'h55);
    check("opimm stall rs2", rs2, 32'hFFFFFFFF);
    check("opimm stall rs1", rs1, 32'd9);

    // Reset mid-stall drops the held word and clears the register file.
    #2 rst_n = 1'b0;
    #1;
    check("midstall reset out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    check("post reset no output", 32'(out_valid), 32'd0);
    instr_valid = 1'b1; instr = 32'h002081B3;
    cycle();
    instr_valid = 1'b0;
    check("post reset x1", rs1, 32'd0);
    check("post reset x2", rs2, 32'd0);
    check("post reset out_valid", 32'(out_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
